wb_master_burst: RTL and testbench

//  Parametrised Wishbone B4 master engine; successor to the single-beat CPU master stub.
//  - Issues single or incrementing-burst (CTI 010) transfers of up to MAX_BURST beats.
//  - Retries on RTY up to a configurable limit, and aborts cleanly on ERR.
//  - Sits between the CPU/test command port and the wishbone interconnect master slot.

---
 rtl/wb_master_burst.sv | 183 ++++++++++++++++++
 tb/tb_wb_master_burst.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_burst.sv
// Wishbone B4 master engine: single or incrementing-burst transfers with RTY retry and ERR abort.
// Optional per-beat watchdog is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_burst #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int MAX_BURST   = 16,
  parameter int LW          = $clog2(MAX_BURST),
  parameter int RETRY_LIMIT = 3,
  parameter int TIMEOUT     = 256
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  output logic [aw-1:0] wb_m_adr_o,
  output logic [dw-1:0] wb_m_dat_o,
  output logic [3:0]    wb_m_sel_o,
  output logic          wb_m_we_o,
  output logic          wb_m_cyc_o,
  output logic          wb_m_stb_o,
  output logic [2:0]    wb_m_cti_o,
  output logic [1:0]    wb_m_bte_o,
  input  logic [dw-1:0] wb_m_dat_i,
  input  logic          wb_m_ack_i,
  input  logic          wb_m_err_i,
  input  logic          wb_m_rty_i,
  input  logic          start,
  input  logic [aw-1:0] address,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [LW-1:0] burst_len,
  input  logic [dw-1:0] data_wr,
  output logic          wr_next,
  output logic [dw-1:0] data_rd,
  output logic          rd_valid,
  output logic          active,
  output logic          done,
  output logic          error,
  output logic          timeout
);

  typedef enum logic [1:0] {IDLE, BUS, RWAIT, DONE} state_t;

  localparam int RW = $clog2(RETRY_LIMIT + 2);
  localparam logic [RW-1:0] RTY_LIM = RW'(RETRY_LIMIT);

  state_t          state, state_nxt;
  logic [aw-1:0]   adr_q;
  logic [3:0]      sel_q;
  logic            we_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   beat_q;
  logic [RW-1:0]   rty_q;
  logic            error_q;
  logic            wr_next_p1;
  logic            rd_valid_p1;
  logic [dw-1:0]   data_rd_p1;
  logic            last_beat;
  logic            bus_ack, bus_rty, bus_err, rty_abort;
  logic            tmo_hit;

  // ERR outranks RTY, which outranks ACK
  assign bus_err   = (state == BUS) && wb_m_err_i;
  assign bus_rty   = (state == BUS) && wb_m_rty_i && !wb_m_err_i;
  assign bus_ack   = (state == BUS) && wb_m_ack_i && !wb_m_err_i && !wb_m_rty_i;
  assign rty_abort = (rty_q >= RTY_LIM);
  assign last_beat = (beat_q == len_q);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          timeout_q;
  logic          bus_quiet;

  assign bus_quiet = (state == BUS) && !wb_m_ack_i && !wb_m_err_i && !wb_m_rty_i;
  assign tmo_hit   = bus_quiet && (tmo_q == TW'(TIMEOUT - 1));

  // Counter only runs through silent BUS cycles; any other state or response clears it
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && start) timeout_q <= 1'b0;
      if (tmo_hit) timeout_q <= 1'b1;
      if (bus_quiet) tmo_q <= tmo_q + 1'b1;
      else           tmo_q <= '0;
    end
  end

  assign timeout = timeout_q;
`else
  // No watchdog in this build: a silent slave holds BUS indefinitely
  assign tmo_hit = (TIMEOUT < 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = BUS;
      BUS: begin
        if (bus_err)                   state_nxt = DONE;
        else if (bus_rty)              state_nxt = rty_abort ? DONE : RWAIT;
        else if (bus_ack && last_beat) state_nxt = DONE;
        else if (tmo_hit)              state_nxt = DONE;
      end
      RWAIT: state_nxt = BUS;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response stage: beat handshakes become the _p1 pulses one cycle later
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      adr_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      rty_q       <= '0;
      error_q     <= 1'b0;
      wr_next_p1  <= 1'b0;
      rd_valid_p1 <= 1'b0;
      data_rd_p1  <= '0;
    end else begin
      wr_next_p1  <= bus_ack && we_q;
      rd_valid_p1 <= bus_ack && !we_q;
      if (bus_ack && !we_q) data_rd_p1 <= wb_m_dat_i;
      if (state == IDLE && start) begin
        adr_q   <= address;
        sel_q   <= selection;
        we_q    <= write;
        len_q   <= burst_len;
        beat_q  <= '0;
        rty_q   <= '0;
        error_q <= 1'b0;
      end
      if (bus_ack) begin
        adr_q  <= adr_q + aw'(4);
        beat_q <= beat_q + 1'b1;
        rty_q  <= '0;
      end
      if (bus_rty && !rty_abort) rty_q <= rty_q + 1'b1;
      if (bus_err || (bus_rty && rty_abort) || tmo_hit) error_q <= 1'b1;
    end
  end

  always_comb begin
    wb_m_cyc_o = 1'b0;
    wb_m_stb_o = 1'b0;
    wb_m_cti_o = 3'b000;
    wb_m_dat_o = '0;
    active     = 1'b0;
    done       = 1'b0;
    case (state)
      BUS: begin
        wb_m_cyc_o = 1'b1;
        wb_m_stb_o = 1'b1;
        active     = 1'b1;
        if (len_q != '0) wb_m_cti_o = last_beat ? 3'b111 : 3'b010;
        if (we_q) wb_m_dat_o = data_wr;
      end
      RWAIT:   active = 1'b1;
      DONE:    done   = 1'b1;
      default: ;
    endcase
  end

  assign wb_m_adr_o = adr_q;
  assign wb_m_sel_o = sel_q;
  assign wb_m_we_o  = we_q;
  assign wb_m_bte_o = 2'b00;
  assign wr_next    = wr_next_p1;
  assign rd_valid   = rd_valid_p1;
  assign data_rd    = data_rd_p1;
  assign error      = error_q;

endmodule

// File: tb/tb_wb_master_burst.sv
// Directed bench for wb_master_burst: bus-side slave driven from per-cycle response scripts.
// Response codes: 0 none, 1 ACK, 2 RTY, 3 ERR.
module tb_wb_master_burst;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_m_adr_o, wb_m_dat_o, wb_m_dat_i;
  logic [3:0]  wb_m_sel_o;
  logic        wb_m_we_o, wb_m_cyc_o, wb_m_stb_o;
  logic [2:0]  wb_m_cti_o;
  logic [1:0]  wb_m_bte_o;
  logic        wb_m_ack_i, wb_m_err_i, wb_m_rty_i;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [3:0]  burst_len;
  logic [31:0] data_wr, data_rd;
  logic        wr_next, rd_valid, active, done, error, timeout;

  wb_master_burst #(.dw(32), .aw(32), .MAX_BURST(16), .LW(4), .RETRY_LIMIT(3), .TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_m_adr_o(wb_m_adr_o), .wb_m_dat_o(wb_m_dat_o), .wb_m_sel_o(wb_m_sel_o),
    .wb_m_we_o(wb_m_we_o), .wb_m_cyc_o(wb_m_cyc_o), .wb_m_stb_o(wb_m_stb_o),
    .wb_m_cti_o(wb_m_cti_o), .wb_m_bte_o(wb_m_bte_o), .wb_m_dat_i(wb_m_dat_i),
    .wb_m_ack_i(wb_m_ack_i), .wb_m_err_i(wb_m_err_i), .wb_m_rty_i(wb_m_rty_i),
    .start(start), .address(address), .selection(selection), .write(write),
    .burst_len(burst_len), .data_wr(data_wr), .wr_next(wr_next), .data_rd(data_rd),
    .rd_valid(rd_valid), .active(active), .done(done), .error(error), .timeout(timeout)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int failures = 0;

  int          script[16];
  int          slen;
  logic [31:0] wbase, rbase;
  logic [31:0] adr_log[32];
  logic [2:0]  cti_log[32];
  logic [31:0] rd_log[32];
  int          cyc_cnt, drops, rd_cnt, wr_cnt, acks;
  logic        done_seen, cyc_at_done, err_at_done, tmo_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_script(input int n, input int r0, input int r1, input int r2, input int r3);
    slen = n;
    script[0] = r0; script[1] = r1; script[2] = r2; script[3] = r3;
  endtask

  task automatic idle_bus();
    wb_m_ack_i = 1'b0; wb_m_err_i = 1'b0; wb_m_rty_i = 1'b0; wb_m_dat_i = '0;
  endtask

  task automatic run_cmd(input logic [31:0] adr, input logic we, input logic [3:0] len, input int budget);
    int resp;
    cyc_cnt = 0; drops = 0; rd_cnt = 0; wr_cnt = 0; acks = 0;
    done_seen = 1'b0; cyc_at_done = 1'b0; err_at_done = 1'b0; tmo_at_done = 1'b0;
    start = 1'b1; address = adr; selection = 4'hF; write = we; burst_len = len; data_wr = wbase;
    step();
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rd_valid) begin rd_log[rd_cnt] = data_rd; rd_cnt++; end
      if (wr_next) begin wr_cnt++; data_wr = wbase + wr_cnt; end
      if (done) begin
        done_seen = 1'b1; cyc_at_done = wb_m_cyc_o; err_at_done = error; tmo_at_done = timeout;
        idle_bus();
        break;
      end
      #1;
      if (wb_m_cyc_o) begin
        adr_log[cyc_cnt] = wb_m_adr_o;
        cti_log[cyc_cnt] = wb_m_cti_o;
        if (we) check("wdata", wb_m_dat_o, wbase + acks);
        check("stb", wb_m_stb_o, 1'b1);
        check("we", wb_m_we_o, we);
        resp = (cyc_cnt < slen) ? script[cyc_cnt] : 0;
        wb_m_ack_i = (resp == 1);
        wb_m_rty_i = (resp == 2);
        wb_m_err_i = (resp == 3);
        wb_m_dat_i = rbase + acks;
        if (resp == 1) acks++;
        cyc_cnt++;
      end else begin
        idle_bus();
        if (active) drops++;
      end
      step();
    end
    check("done_seen", done_seen, 1'b1);
    step();
  endtask

  initial begin
    wb_rst = 1'b1; start = 1'b0; address = '0; selection = '0; write = 1'b0;
    burst_len = '0; data_wr = '0; wbase = '0; rbase = '0; slen = 0;
    idle_bus();
    repeat (3) step();
    check("rst_cyc", wb_m_cyc_o, 1'b0);
    check("rst_adr", wb_m_adr_o, 32'h0);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    wb_rst = 1'b0;
    step();

    // single write, ACK on third bus cycle
    wbase = 32'h1111_0000;
    set_script(3, 0, 0, 1, 0);
    run_cmd(32'h1000, 1'b1, 4'd0, 20);
    check("t1_cyc_cnt", cyc_cnt, 3);
    for (int i = 0; i < 3; i++) check("t1_cti", cti_log[i], 3'b000);
    check("t1_adr", adr_log[0], 32'h1000);
    check("t1_wr_next", wr_cnt, 1);
    check("t1_error", err_at_done, 1'b0);
    check("t1_sel", wb_m_sel_o, 4'hF);

    // 4-beat read burst, ACK every cycle
    rbase = 32'hA0;
    set_script(4, 1, 1, 1, 1);
    run_cmd(32'h2000, 1'b0, 4'd3, 20);
    check("t2_cyc_cnt", cyc_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_adr", adr_log[i], 32'h2000 + 4 * i);
      check("t2_cti", cti_log[i], (i == 3) ? 3'b111 : 3'b010);
      check("t2_rdata", rd_log[i], 32'hA0 + i);
    end
    check("t2_rd_cnt", rd_cnt, 4);
    check("t2_drops", drops, 0);
    check("t2_error", err_at_done, 1'b0);

    // RTY twice then ACK
    rbase = 32'hB0;
    set_script(3, 2, 2, 1, 0);
    run_cmd(32'h3000, 1'b0, 4'd0, 20);
    check("t3_cyc_cnt", cyc_cnt, 3);
    check("t3_drops", drops, 2);
    for (int i = 0; i < 3; i++) check("t3_adr", adr_log[i], 32'h3000);
    check("t3_rd_cnt", rd_cnt, 1);
    check("t3_rdata", rd_log[0], 32'hB0);
    check("t3_error", err_at_done, 1'b0);

    // RTY four times exhausts the retry limit
    set_script(4, 2, 2, 2, 2);
    run_cmd(32'h4000, 1'b0, 4'd0, 20);
    check("t4_cyc_cnt", cyc_cnt, 4);
    check("t4_drops", drops, 3);
    check("t4_rd_cnt", rd_cnt, 0);
    check("t4_error", err_at_done, 1'b1);

    // 4-beat write, ERR on second beat
    wbase = 32'h5555_0000;
    set_script(2, 1, 3, 0, 0);
    run_cmd(32'h5000, 1'b1, 4'd3, 20);
    check("t5_cyc_cnt", cyc_cnt, 2);
    check("t5_wr_next", wr_cnt, 1);
    check("t5_adr1", adr_log[1], 32'h5004);
    check("t5_cti0", cti_log[0], 3'b010);
    check("t5_error", err_at_done, 1'b1);
    check("t5_cyc_at_done", cyc_at_done, 1'b0);
    check("t5_timeout", tmo_at_done, 1'b0);
    check("t5_err_sticky", error, 1'b1);

    // address wraps past the top, error cleared by new start
    rbase = 32'hC0;
    set_script(2, 1, 1, 0, 0);
    run_cmd(32'hFFFF_FFFC, 1'b0, 4'd1, 20);
    check("tw_adr0", adr_log[0], 32'hFFFF_FFFC);
    check("tw_adr1", adr_log[1], 32'h0000_0000);
    check("tw_cti0", cti_log[0], 3'b010);
    check("tw_cti1", cti_log[1], 3'b111);
    check("tw_rdata1", rd_log[1], 32'hC1);
    check("tw_error", err_at_done, 1'b0);

`ifdef WB_MASTER_TIMEOUT_EN
    // silent slave trips the watchdog after 16 bus cycles
    set_script(0, 0, 0, 0, 0);
    run_cmd(32'h6000, 1'b0, 4'd1, 60);
    check("t6_cyc_cnt", cyc_cnt, 16);
    check("t6_error", err_at_done, 1'b1);
    check("t6_timeout", tmo_at_done, 1'b1);
`endif

    // reset in the middle of a write burst
    wbase = 32'h7777_0000;
    start = 1'b1; address = 32'h7000; write = 1'b1; burst_len = 4'd7; data_wr = wbase;
    step();
    start = 1'b0;
    check("t7_cyc_before", wb_m_cyc_o, 1'b1);
    wb_m_ack_i = 1'b1;
    step();
    step();
    idle_bus();
    wb_rst = 1'b1;
    step();
    check("t7_cyc", wb_m_cyc_o, 1'b0);
    check("t7_stb", wb_m_stb_o, 1'b0);
    check("t7_adr", wb_m_adr_o, 32'h0);
    check("t7_dat", wb_m_dat_o, 32'h0);
    check("t7_cti", wb_m_cti_o, 3'b000);
    check("t7_we", wb_m_we_o, 1'b0);
    check("t7_wr_next", wr_next, 1'b0);
    check("t7_active", active, 1'b0);
    check("t7_done", done, 1'b0);
    check("t7_error", error, 1'b0);
    check("t7_timeout", timeout, 1'b0);
    wb_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_no_done", done, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
